// File: rtl/spi_dev_arbiter_pkg.sv
// Shared types and constants for the SPI device arbiter.
// Holds the controller state encoding, the device-select constants and the
// request record that is muxed from the winning requester.
package spi_dev_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE,
    GAP
  } state_t;

  localparam logic DEV_FLASH = 1'b0;
  localparam logic DEV_SD    = 1'b1;

  // One requester's byte request as seen at the grant point.
  typedef struct packed {
    logic       dev;
    logic       keep;
    logic [7:0] tx;
  } req_t;

endpackage

// File: rtl/spi_dev_arbiter_if.sv
// One requester port of the SPI arbiter: valid/ready request plus done/rx return.
// master: requester side (drives valid/dev/keep/tx).
// slave:  arbiter side (drives ready/done/rx; ready and done are 1-cycle pulses).
interface spi_dev_arbiter_if;
  logic       valid;
  logic       dev;
  logic       keep;
  logic [7:0] tx;
  logic       ready;
  logic       done;
  logic [7:0] rx;

  modport master (output valid, dev, keep, tx, input ready, done, rx);
  modport slave  (input valid, dev, keep, tx, output ready, done, rx);
endinterface

// File: rtl/spi_dev_arbiter_byte_shifter.sv
// Mode-0 MSB-first SPI byte shifter with a CLKDIV prescaler.
// Latency: start -> done strobe is CLKDIV (setup) + 16*CLKDIV (8 SCK periods) cycles.
// Backpressure: start is ignored while a byte is in flight; the caller owns sequencing.
// Ports: clk/rst; start + tx in; miso in; sck/mosi out; load_end/done strobes
// (high in the cycle whose closing edge ends that phase); rx holds the sampled byte.
module spi_byte_shifter #(
  parameter int CLKDIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx,
  input  logic       miso,
  output logic       sck,
  output logic       mosi,
  output logic       load_end,
  output logic       done,
  output logic [7:0] rx
);

  localparam logic [7:0] DIV_LAST = 8'(CLKDIV - 1);

  logic       busy;
  logic       loading;
  logic [7:0] div_cnt;
  logic [3:0] half_cnt;
  logic [6:0] tx_sr;
  logic       div_end;

  assign div_end  = (div_cnt == DIV_LAST);
  assign load_end = busy && loading && div_end;
  // Half 15 is the trailing low half after the 8th falling edge: no SCK edge there.
  assign done     = busy && !loading && div_end && (half_cnt == 4'd15);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 1'b0;
      loading  <= 1'b0;
      div_cnt  <= '0;
      half_cnt <= '0;
      tx_sr    <= '0;
      sck      <= 1'b0;
      mosi     <= 1'b1;
      rx       <= '0;
    end else if (start && !busy) begin
      // First bit goes out with CS, before any SCK edge.
      busy     <= 1'b1;
      loading  <= 1'b1;
      div_cnt  <= '0;
      half_cnt <= '0;
      tx_sr    <= tx[6:0];
      mosi     <= tx[7];
      sck      <= 1'b0;
    end else if (busy) begin
      if (!div_end) begin
        div_cnt <= div_cnt + 8'd1;
      end else begin
        div_cnt <= '0;
        if (loading) begin
          // End of setup: first rising edge, sample bit 7.
          loading <= 1'b0;
          sck     <= 1'b1;
          rx      <= {rx[6:0], miso};
        end else if (half_cnt == 4'd15) begin
          busy <= 1'b0;
        end else begin
          half_cnt <= half_cnt + 4'd1;
          sck      <= ~sck;
          if (sck) begin
            // Falling edge: present next bit; ones backfill so MOSI idles high.
            mosi  <= tx_sr[6];
            tx_sr <= {tx_sr[5:0], 1'b1};
          end else begin
            rx <= {rx[6:0], miso};
          end
        end
      end
    end
  end

endmodule

// File: rtl/spi_dev_arbiter.sv
// Two-requester arbiter sharing one SPI byte engine between boot flash and SD card.
// Latency: grant (ready pulse) to done pulse is 17*CLKDIV + 1 cycles; CS gap of CLKDIV after release.
// Backpressure: a requester holds valid until ready; a locked owner blocks the other requester.
// Ports: clk, rst (async, active high); r0/r1 requester interfaces (slave side);
// flash_* and sd_* SPI pins; testled activity indicator with hold-time stretch.
module spi_dev_arbiter
  import spi_dev_arbiter_pkg::*;
#(
  parameter int CLKDIV        = 2,
  parameter int LED_HOLD_BITS = 22
) (
  input  logic clk,
  input  logic rst,
  spi_dev_arbiter_if.slave r0,
  spi_dev_arbiter_if.slave r1,
  output logic flash_cs_n,
  output logic flash_clk,
  output logic flash_mosi,
  input  logic flash_miso,
  output logic sd_cs_n,
  output logic sd_clk,
  output logic sd_mosi,
  input  logic sd_miso,
  output logic testled
);

  localparam logic [7:0]               GAP_LAST = 8'(CLKDIV - 1);
  localparam logic [LED_HOLD_BITS-1:0] LED_MAX  = '1;

  state_t state_q, state_d;
  logic   owner_q;        // last granted requester; meaningful as lock owner when locked_q
  logic   locked_q;
  logic   dev_q;
  logic   keep_q;
  logic   cs_on_q;        // selected device's CS asserted
  logic [7:0] gap_cnt_q;

  logic       r0_ready_q, r1_ready_q, r0_done_q, r1_done_q;
  logic [7:0] r0_rx_q, r1_rx_q;

  logic [LED_HOLD_BITS-1:0] led_cnt_q;
  logic                     led_q;

  logic   grant, grant_id, cs_drop;
  logic   owner_valid, owner_dev;
  req_t   grant_req;

  logic       sh_sck, sh_mosi, sh_miso, sh_load_end, sh_done;
  logic [7:0] sh_rx;

  assign owner_valid = owner_q ? r1.valid : r0.valid;
  assign owner_dev   = owner_q ? r1.dev   : r0.dev;
  assign grant_req   = grant_id ? {r1.dev, r1.keep, r1.tx} : {r0.dev, r0.keep, r0.tx};

  always_comb begin
    state_d  = state_q;
    grant    = 1'b0;
    grant_id = 1'b0;
    cs_drop  = 1'b0;
    case (state_q)
      IDLE: begin
        if (locked_q) begin
          if (owner_valid) begin
            // Locked owner switching device: release old CS through a gap first.
            if (cs_on_q && (owner_dev != dev_q)) begin
              cs_drop = 1'b1;
              state_d = GAP;
            end else begin
              grant    = 1'b1;
              grant_id = owner_q;
            end
          end
        end else if (r0.valid) begin
          grant    = 1'b1;
          grant_id = 1'b0;
        end else if (r1.valid) begin
          grant    = 1'b1;
          grant_id = 1'b1;
        end
        if (grant) state_d = LOAD;
      end
      LOAD:    if (sh_load_end) state_d = SHIFT;
      SHIFT:   if (sh_done) state_d = DONE;
      DONE:    state_d = keep_q ? IDLE : GAP;
      GAP:     if (gap_cnt_q == GAP_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      locked_q   <= 1'b0;
      dev_q      <= DEV_FLASH;
      keep_q     <= 1'b0;
      cs_on_q    <= 1'b0;
      gap_cnt_q  <= '0;
      r0_ready_q <= 1'b0;
      r1_ready_q <= 1'b0;
      r0_done_q  <= 1'b0;
      r1_done_q  <= 1'b0;
      r0_rx_q    <= '0;
      r1_rx_q    <= '0;
    end else begin
      state_q    <= state_d;
      r0_ready_q <= grant && !grant_id;
      r1_ready_q <= grant && grant_id;
      r0_done_q  <= 1'b0;
      r1_done_q  <= 1'b0;
      gap_cnt_q  <= (state_q == GAP) ? gap_cnt_q + 8'd1 : 8'd0;
      if (grant) begin
        owner_q <= grant_id;
        dev_q   <= grant_req.dev;
        keep_q  <= grant_req.keep;
        cs_on_q <= 1'b1;
      end
      if (cs_drop) cs_on_q <= 1'b0;
      if (state_q == DONE) begin
        if (owner_q) begin
          r1_rx_q   <= sh_rx;
          r1_done_q <= 1'b1;
        end else begin
          r0_rx_q   <= sh_rx;
          r0_done_q <= 1'b1;
        end
        locked_q <= keep_q;
        if (!keep_q) cs_on_q <= 1'b0;
      end
    end
  end

  // LED: lit while any CS is low, then held for 2^LED_HOLD_BITS cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_cnt_q <= LED_MAX;
      led_q     <= 1'b0;
    end else begin
      if (cs_on_q) led_cnt_q <= '0;
      else if (led_cnt_q != LED_MAX) led_cnt_q <= led_cnt_q + 1'b1;
      led_q <= cs_on_q || (led_cnt_q != LED_MAX);
    end
  end

  assign testled = cs_on_q | led_q;

  assign r0.ready = r0_ready_q;
  assign r1.ready = r1_ready_q;
  assign r0.done  = r0_done_q;
  assign r1.done  = r1_done_q;
  assign r0.rx    = r0_rx_q;
  assign r1.rx    = r1_rx_q;

  // Pin routing: CS/SCK/MOSI reach only the selected device; the other idles.
  logic flash_sel, sd_sel;
  assign flash_sel  = cs_on_q && (dev_q == DEV_FLASH);
  assign sd_sel     = cs_on_q && (dev_q == DEV_SD);
  assign flash_cs_n = !flash_sel;
  assign flash_clk  = flash_sel && sh_sck;
  assign flash_mosi = flash_sel ? sh_mosi : 1'b1;
  assign sd_cs_n    = !sd_sel;
  assign sd_clk     = sd_sel && sh_sck;
  assign sd_mosi    = sd_sel ? sh_mosi : 1'b1;
  assign sh_miso    = (dev_q == DEV_SD) ? sd_miso : flash_miso;

  spi_byte_shifter #(.CLKDIV(CLKDIV)) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .start    (grant),
    .tx       (grant_req.tx),
    .miso     (sh_miso),
    .sck      (sh_sck),
    .mosi     (sh_mosi),
    .load_end (sh_load_end),
    .done     (sh_done),
    .rx       (sh_rx)
  );

endmodule

// File: tb/tb_spi_dev_arbiter.sv
module tb_spi_dev_arbiter;
  import spi_dev_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spi_dev_arbiter_if r0_if ();
  spi_dev_arbiter_if r1_if ();

  logic flash_cs_n, flash_clk, flash_mosi, flash_miso;
  logic sd_cs_n, sd_clk, sd_mosi, sd_miso, testled;

  spi_dev_arbiter #(.CLKDIV(2), .LED_HOLD_BITS(4)) dut (
    .clk(clk), .rst(rst), .r0(r0_if), .r1(r1_if),
    .flash_cs_n(flash_cs_n), .flash_clk(flash_clk), .flash_mosi(flash_mosi), .flash_miso(flash_miso),
    .sd_cs_n(sd_cs_n), .sd_clk(sd_clk), .sd_mosi(sd_mosi), .sd_miso(sd_miso),
    .testled(testled)
  );

  // SPI slave models: shift pattern out on SCK falling, capture MOSI on rising.
  logic [7:0] fl_pat = 8'hEF, sd_pat = 8'h5A;
  logic [2:0] fl_idx = 3'd0, sd_idx = 3'd0;
  logic [7:0] fl_cap = 8'h00, sd_cap = 8'h00;

  always @(negedge flash_clk or posedge flash_cs_n)
    if (flash_cs_n) fl_idx <= 3'd0; else fl_idx <= fl_idx + 3'd1;
  always @(negedge sd_clk or posedge sd_cs_n)
    if (sd_cs_n) sd_idx <= 3'd0; else sd_idx <= sd_idx + 3'd1;
  assign flash_miso = fl_pat[3'd7 - fl_idx];
  assign sd_miso    = sd_pat[3'd7 - sd_idx];
  always @(posedge flash_clk) fl_cap <= {fl_cap[6:0], flash_mosi};
  always @(posedge sd_clk)    sd_cap <= {sd_cap[6:0], sd_mosi};

  int cyc = 0;
  int overlap = 0;
  int sd_low = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (!flash_cs_n && !sd_cs_n) overlap++;
    if (!sd_cs_n) sd_low++;
  end

  int checks = 0, failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int rq, input logic v, input logic dev, input logic keep, input logic [7:0] tx);
    if (rq == 0) begin
      r0_if.valid = v; r0_if.dev = dev; r0_if.keep = keep; r0_if.tx = tx;
    end else begin
      r1_if.valid = v; r1_if.dev = dev; r1_if.keep = keep; r1_if.tx = tx;
    end
  endtask

  function automatic logic rdy_of(input int rq);
    return (rq == 0) ? r0_if.ready : r1_if.ready;
  endfunction
  function automatic logic done_of(input int rq);
    return (rq == 0) ? r0_if.done : r1_if.done;
  endfunction
  function automatic logic [7:0] rx_of(input int rq);
    return (rq == 0) ? r0_if.rx : r1_if.rx;
  endfunction
  function automatic logic cs_hi(input logic dev);
    return dev ? sd_cs_n : flash_cs_n;
  endfunction

  // One transfer, called at a negedge. cs_gap counts cycles between ready and
  // done (and the done cycle itself when keep=1) where the target CS was high.
  task automatic xfer(input int rq, input logic dev, input logic keep, input logic [7:0] tx,
                      output int t_rdy, output int t_done, output logic [7:0] rx, output int cs_gap);
    logic ok;
    int n;
    cs_gap = 0;
    drive(rq, 1'b1, dev, keep, tx);
    ok = 1'b0;
    n = 0;
    while (!ok && n < 400) begin
      @(negedge clk);
      n++;
      ok = rdy_of(rq);
    end
    check_eq("ready_seen", ok, 1'b1);
    t_rdy = cyc;
    drive(rq, 1'b0, dev, keep, tx);
    ok = 1'b0;
    n = 0;
    while (!ok && n < 400) begin
      if (cs_hi(dev)) cs_gap++;
      @(negedge clk);
      n++;
      ok = done_of(rq);
    end
    if (keep && cs_hi(dev)) cs_gap++;
    check_eq("done_seen", ok, 1'b1);
    t_done = cyc;
    rx = rx_of(rq);
  endtask

  int a_rdy, a_done, a_gap, b_rdy, b_done, b_gap;
  int c_rdy, c_done, c_gap, w_rdy, w_done, w_gap;
  int l1r, l1d, l1g, l2r, l2d, l2g, l3r, l3d, l3g;
  logic [7:0] a_rx, b_rx, c_rx, w_rx, l1x, l2x, l3x;
  int n_led, n_cnt;
  logic seen;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    drive(0, 1'b0, 1'b0, 1'b0, 8'h00);
    drive(1, 1'b0, 1'b0, 1'b0, 8'h00);
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_flash_pins", {flash_cs_n, flash_clk, flash_mosi}, 3'b101);
    check_eq("rst_sd_pins", {sd_cs_n, sd_clk, sd_mosi}, 3'b101);
    check_eq("rst_pulses", {r0_if.ready, r0_if.done, r1_if.ready, r1_if.done}, 4'b0000);
    check_eq("rst_rx", {r0_if.rx, r1_if.rx}, 16'h0000);
    check_eq("rst_led", testled, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single transfer, r0 to flash, then LED hold.
    fl_pat = 8'hEF;
    xfer(0, DEV_FLASH, 1'b0, 8'h9F, a_rdy, a_done, a_rx, a_gap);
    check_eq("t1_latency", a_done - a_rdy, 35);
    check_eq("t1_rx", a_rx, 8'hEF);
    check_eq("t1_mosi", fl_cap, 8'h9F);
    check_eq("t1_cs_held", a_gap, 0);
    check_eq("t1_sd_idle", sd_low, 0);
    n_led = 0;
    while (testled && n_led < 100) begin
      n_led++;
      @(negedge clk);
    end
    check_eq("t1_led_hold", n_led, 16);
    repeat (3) @(negedge clk);

    // Contention: r0 wins, r1 after the gap.
    fl_pat = 8'h81; sd_pat = 8'h5A;
    fork
      xfer(0, DEV_FLASH, 1'b0, 8'hA5, a_rdy, a_done, a_rx, a_gap);
      xfer(1, DEV_SD, 1'b0, 8'h3C, b_rdy, b_done, b_rx, b_gap);
    join
    check_eq("t2_order", b_rdy - a_rdy, 38);
    check_eq("t2_cs_gap", b_rdy - a_done, 3);
    check_eq("t2_r0_rx", a_rx, 8'h81);
    check_eq("t2_r1_rx", b_rx, 8'h5A);
    check_eq("t2_sd_mosi", sd_cap, 8'h3C);
    check_eq("t2_cs_held", a_gap + b_gap, 0);
    repeat (3) @(negedge clk);

    // Lock: r1 holds SD for three bytes while r0 waits.
    sd_pat = 8'hC6;
    fork
      begin
        xfer(1, DEV_SD, 1'b1, 8'h11, l1r, l1d, l1x, l1g);
        xfer(1, DEV_SD, 1'b1, 8'h22, l2r, l2d, l2x, l2g);
        xfer(1, DEV_SD, 1'b0, 8'h33, l3r, l3d, l3x, l3g);
      end
      begin
        repeat (5) @(negedge clk);
        xfer(0, DEV_FLASH, 1'b0, 8'h44, w_rdy, w_done, w_rx, w_gap);
      end
    join
    check_eq("t3_sd_continuous", l1g + l2g + l3g, 0);
    check_eq("t3_b2_follow", l2r - l1d, 1);
    check_eq("t3_b3_follow", l3r - l2d, 1);
    check_eq("t3_r0_after_unlock", w_rdy - l3d, 3);
    check_eq("t3_rx", {l1x, l3x}, 16'hC6C6);
    check_eq("t3_r0_rx", w_rx, 8'h81);
    check_eq("t3_sd_mosi", sd_cap, 8'h33);
    repeat (3) @(negedge clk);

    // Device switch under lock.
    fl_pat = 8'h3C; sd_pat = 8'hE7;
    xfer(0, DEV_FLASH, 1'b1, 8'h55, a_rdy, a_done, a_rx, a_gap);
    xfer(0, DEV_SD, 1'b0, 8'hAA, b_rdy, b_done, b_rx, b_gap);
    check_eq("t4_switch_gap", b_rdy - a_done, 4);
    check_eq("t4_rx", {a_rx, b_rx}, 16'h3CE7);
    check_eq("t4_cs_held", a_gap + b_gap, 0);
    check_eq("t4_fl_mosi", fl_cap, 8'h55);
    repeat (3) @(negedge clk);

    // Reset mid-SHIFT with a keep=1 transfer, then another requester proceeds.
    drive(0, 1'b1, DEV_SD, 1'b1, 8'hC3);
    seen = 1'b0;
    n_cnt = 0;
    while (!seen && n_cnt < 100) begin
      @(negedge clk);
      n_cnt++;
      seen = r0_if.ready;
    end
    check_eq("t5_ready_seen", seen, 1'b1);
    drive(0, 1'b0, DEV_SD, 1'b1, 8'hC3);
    repeat (9) @(negedge clk);
    check_eq("t5_cs_low_before", sd_cs_n, 1'b0);
    rst = 1'b1;
    #1;
    check_eq("t5_cs_async_release", {flash_cs_n, sd_cs_n, sd_clk}, 3'b110);
    @(negedge clk);
    rst = 1'b0;
    n_cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (r0_if.done) n_cnt++;
    end
    check_eq("t5_no_done", n_cnt, 0);
    fl_pat = 8'h96;
    xfer(1, DEV_FLASH, 1'b0, 8'h69, c_rdy, c_done, c_rx, c_gap);
    check_eq("t5_after_latency", c_done - c_rdy, 35);
    check_eq("t5_after_rx", c_rx, 8'h96);
    repeat (3) @(negedge clk);

    // Valid dropped before ready: no transfer.
    fork
      xfer(0, DEV_FLASH, 1'b0, 8'h0F, a_rdy, a_done, a_rx, a_gap);
      begin
        n_cnt = 0;
        repeat (4) @(negedge clk);
        drive(1, 1'b1, DEV_SD, 1'b0, 8'hF0);
        repeat (3) begin
          @(negedge clk);
          if (r1_if.ready) n_cnt++;
        end
        drive(1, 1'b0, DEV_SD, 1'b0, 8'hF0);
        repeat (80) begin
          @(negedge clk);
          if (r1_if.ready) n_cnt++;
        end
      end
    join
    check_eq("t6_dropped", n_cnt, 0);
    check_eq("t6_r0_rx", a_rx, 8'h96);

    check_eq("no_cs_overlap", overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
